// File: rtl/activation_pkg.sv
// Shared definitions for the activation stream unit.
//   act_mode_e   : activation selector encodings (3 is decoded as bypass)
//   LEAKY_SHIFT  : right shift applied to negative values in leaky ReLU
//   sat_bounds() : signed clamp range [-2^ifm_bit, 2^ifm_bit - 1]
package activation_pkg;

    typedef enum logic [1:0] {
        MODE_RELU   = 2'd0,
        MODE_LEAKY  = 2'd1,
        MODE_BYPASS = 2'd2
    } act_mode_e;

    localparam int LEAKY_SHIFT = 3;

    typedef struct packed {
        logic signed [31:0] lo;
        logic signed [31:0] hi;
    } sat_bounds_t;

    function automatic sat_bounds_t sat_bounds(input int ifm_bit);
        sat_bounds_t b;
        b.hi = (32'sd1 <<< ifm_bit) - 32'sd1;
        b.lo = -(32'sd1 <<< ifm_bit);
        return b;
    endfunction

endpackage

// File: rtl/act_lane.sv
// One lane of the activation datapath, purely combinational.
// The logic is split at the S1/S2 register boundary owned by the parent:
//   x_i, shift_i -> shr_o        : rounding arithmetic right shift (feeds S1)
//   shr_i, mode_i -> act_o, sat_o : activation + clamp, sat flag (feeds S2)
module act_lane
    import activation_pkg::*;
#(
    parameter int OFM_BIT = 29,
    parameter int IFM_BIT = 8,
    parameter int SHIFT_W = 5
) (
    input  logic signed [OFM_BIT-1:0] x_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    output logic signed [OFM_BIT:0]   shr_o,
    input  logic signed [OFM_BIT:0]   shr_i,
    input  logic        [1:0]         mode_i,
    output logic signed [IFM_BIT:0]   act_o,
    output logic                      sat_o
);

    localparam int YW = OFM_BIT + 1;
    localparam sat_bounds_t BND = sat_bounds(IFM_BIT);
    localparam logic signed [YW-1:0] HI = YW'(BND.hi);
    localparam logic signed [YW-1:0] LO = YW'(BND.lo);

    logic signed [YW-1:0] x_ext;
    logic signed [YW-1:0] rnd;
    logic signed [YW-1:0] act_y;

    // One extra bit of headroom: |x| <= 2^(OFM_BIT-1) plus a half-LSB of at
    // most 2^(OFM_BIT-2) cannot overflow YW bits.
    always_comb begin
        x_ext = {x_i[OFM_BIT-1], x_i};
        rnd   = '0;
        shr_o = x_ext;
        if (int'(shift_i) >= OFM_BIT) begin
            // Whole word shifted out: only the sign survives. Also keeps the
            // half-LSB constant from landing on the sign bit of YW.
            shr_o = {YW{x_i[OFM_BIT-1]}};
        end else if (shift_i != '0) begin
            rnd   = YW'(1) << (shift_i - 1'b1);
            shr_o = (x_ext + rnd) >>> shift_i;
        end
    end

    always_comb begin
        case (mode_i)
            MODE_RELU:  act_y = shr_i[YW-1] ? '0 : shr_i;
            MODE_LEAKY: act_y = shr_i[YW-1] ? (shr_i >>> LEAKY_SHIFT) : shr_i;
            default:    act_y = shr_i;
        endcase
    end

    always_comb begin
        sat_o = 1'b0;
        act_o = act_y[IFM_BIT:0];
        if (act_y > HI) begin
            act_o = HI[IFM_BIT:0];
            sat_o = 1'b1;
        end else if (act_y < LO) begin
            act_o = LO[IFM_BIT:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/activation_stream_unit.sv
// Multi-lane activation stage between the conv accumulator and the IFM buffer.
// Two-stage pipeline (S1: shifted lanes + cfg/tag, S2: activated results) with
// per-stage valid/ready and bubble collapsing; holds up to two beats.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        input handshake; OFM = CH packed signed lanes
//   in_last                  tag carried with the beat to out_last
//   cfg_mode, cfg_shift      sampled with each accepted beat
//   clr_cnt                  synchronous clear of sat_cnt (wins over increment)
//   out_valid/out_ready      output handshake; Activation = CH packed results
//   sat_cnt                  saturating count of clamped lanes at output
module activation_stream_unit
    import activation_pkg::*;
#(
    parameter int OFM_BIT = 29,
    parameter int IFM_BIT = 8,
    parameter int CH      = 4,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH*OFM_BIT-1:0]    OFM,
    input  logic                     in_last,
    input  logic [1:0]               cfg_mode,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     clr_cnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH*(IFM_BIT+1)-1:0] Activation,
    output logic                     out_last,
    output logic [CNT_W-1:0]         sat_cnt
);

    localparam int YW = OFM_BIT + 1;
    localparam int AW = IFM_BIT + 1;
    localparam int NW = $clog2(CH + 1);

    logic [CH-1:0][YW-1:0] shr_c;
    logic [CH-1:0][AW-1:0] act_c;
    logic [CH-1:0]         sat_c;
    logic [NW-1:0]         nsat_c;

    logic                  s1_vld_q,  s1_vld_d;
    logic [CH-1:0][YW-1:0] s1_shr_q,  s1_shr_d;
    logic [1:0]            s1_mode_q, s1_mode_d;
    logic                  s1_last_q, s1_last_d;

    logic                  s2_vld_q,  s2_vld_d;
    logic [CH-1:0][AW-1:0] s2_act_q,  s2_act_d;
    logic                  s2_last_q, s2_last_d;
    logic [NW-1:0]         s2_nsat_q, s2_nsat_d;

    logic [CNT_W-1:0]      sat_cnt_q, sat_cnt_d;
    logic [CNT_W:0]        cnt_sum;
    logic                  s1_load, s2_load;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        act_lane #(
            .OFM_BIT (OFM_BIT),
            .IFM_BIT (IFM_BIT),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .x_i     (OFM[g*OFM_BIT +: OFM_BIT]),
            .shift_i (cfg_shift),
            .shr_o   (shr_c[g]),
            .shr_i   (s1_shr_q[g]),
            .mode_i  (s1_mode_q),
            .act_o   (act_c[g]),
            .sat_o   (sat_c[g])
        );
    end

    always_comb begin
        nsat_c = '0;
        for (int i = 0; i < CH; i++) begin
            nsat_c = nsat_c + NW'(sat_c[i]);
        end
    end

    always_comb begin
        s2_load  = !s2_vld_q || out_ready;
        s1_load  = !s1_vld_q || s2_load;
        in_ready = s1_load;

        s1_vld_d  = s1_load ? in_valid : s1_vld_q;
        s1_shr_d  = s1_shr_q;
        s1_mode_d = s1_mode_q;
        s1_last_d = s1_last_q;
        if (s1_load && in_valid) begin
            s1_shr_d  = shr_c;
            s1_mode_d = cfg_mode;
            s1_last_d = in_last;
        end

        // Data regs only move when a real beat arrives, so outputs stay
        // stable under backpressure and while the pipe is idle.
        s2_vld_d  = s2_load ? s1_vld_q : s2_vld_q;
        s2_act_d  = s2_act_q;
        s2_last_d = s2_last_q;
        s2_nsat_d = s2_nsat_q;
        if (s2_load && s1_vld_q) begin
            s2_act_d  = act_c;
            s2_last_d = s1_last_q;
            s2_nsat_d = nsat_c;
        end

        cnt_sum   = {1'b0, sat_cnt_q} + (CNT_W+1)'(s2_nsat_q);
        sat_cnt_d = sat_cnt_q;
        if (clr_cnt) begin
            sat_cnt_d = '0;
        end else if (s2_vld_q && out_ready) begin
            sat_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_shr_q  <= '0;
            s1_mode_q <= '0;
            s1_last_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_act_q  <= '0;
            s2_last_q <= 1'b0;
            s2_nsat_q <= '0;
            sat_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_shr_q  <= s1_shr_d;
            s1_mode_q <= s1_mode_d;
            s1_last_q <= s1_last_d;
            s2_vld_q  <= s2_vld_d;
            s2_act_q  <= s2_act_d;
            s2_last_q <= s2_last_d;
            s2_nsat_q <= s2_nsat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign Activation = s2_act_q;
    assign out_last   = s2_last_q;
    assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_activation_stream_unit.sv
module tb_activation_stream_unit;

    localparam int OFM_BIT = 29;
    localparam int IFM_BIT = 8;
    localparam int CH      = 4;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 16;
    localparam int AW      = IFM_BIT + 1;
    localparam longint HI  = (longint'(1) << IFM_BIT) - 1;
    localparam longint LO  = -(longint'(1) << IFM_BIT);
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int BUDGET  = 200;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [CH*OFM_BIT-1:0]  OFM;
    logic                   in_last;
    logic [1:0]             cfg_mode;
    logic [SHIFT_W-1:0]     cfg_shift;
    logic                   clr_cnt;
    logic                   out_valid;
    logic                   out_ready;
    logic [CH*AW-1:0]       Activation;
    logic                   out_last;
    logic [CNT_W-1:0]       sat_cnt;

    activation_stream_unit #(
        .OFM_BIT(OFM_BIT), .IFM_BIT(IFM_BIT), .CH(CH), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .OFM(OFM),
        .in_last(in_last), .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .clr_cnt(clr_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .Activation(Activation),
        .out_last(out_last), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lane[CH];
        bit last;
        int nsat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   acc_cnt = 0;
    int   stall_total = 0;
    int   gaps = 0;
    bit   burst_on = 0;
    bit   seen_first = 0;
    bit   bp_done = 0;
    int   rdy_mode = 0;   // 0 ready, 1 stalled, 2 toggle, 3 random
    int   cur_lanes[CH];

    // ---------------- reference model ----------------
    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int ref_lane(input int x, input int mode, input int s, output bit sat);
        longint y, a, c;
        if (s == 0) y = x;
        else if (s >= OFM_BIT) y = (x < 0) ? -1 : 0;
        else y = fdiv(longint'(x) + (longint'(1) << (s - 1)), longint'(1) << s);
        case (mode)
            0:       a = (y < 0) ? 0 : y;
            1:       a = (y < 0) ? fdiv(y, 8) : y;
            default: a = y;
        endcase
        c = (a > HI) ? HI : ((a < LO) ? LO : a);
        sat = (c != a);
        return int'(c);
    endfunction

    function automatic int sext(input logic [31:0] r);
        logic [OFM_BIT-1:0] v;
        v = r[OFM_BIT-1:0];
        return int'($signed(v));
    endfunction

    function automatic int rnd_lane();
        int k;
        k = int'($urandom_range(0, 4));
        case (k)
            0: return sext($urandom);
            1: return int'($urandom_range(0, 2000)) - 1000;
            2: return int'($urandom_range(0, 8000)) - 4000;
            3: return int'($urandom_range(0, 600)) - 300;
            default: begin
                case ($urandom_range(0, 3))
                    0: return (1 << (OFM_BIT - 1)) - 1;
                    1: return -(1 << (OFM_BIT - 1));
                    2: return -1;
                    default: return 0;
                endcase
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // Drive one beat from cur_lanes and hold it until accepted.
    task automatic send(input int m, input int s, input bit last);
        int n;
        for (int i = 0; i < CH; i++) OFM[i*OFM_BIT +: OFM_BIT] = cur_lanes[i][OFM_BIT-1:0];
        cfg_mode  = m[1:0];
        cfg_shift = s[SHIFT_W-1:0];
        in_last   = last;
        in_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        stall_total += n;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %0b for %0d cycles", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        cur_lanes[0] = a; cur_lanes[1] = b; cur_lanes[2] = c; cur_lanes[3] = d;
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                2: out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit hs, prev_stall, sflag;
        logic [CH*AW-1:0] prev_act;
        logic prev_last;
        logic signed [AW-1:0] t;
        exp_t e, pe;
        int nsat;
        prev_stall = 0;
        prev_act = '0;
        prev_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                exp_cnt = 0;
                prev_stall = 0;
            end else begin
                chk("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
                if (prev_stall) begin
                    checks++;
                    if (!out_valid || Activation !== prev_act || out_last !== prev_last) begin
                        errors++;
                        $display("FAIL hold: valid=%0b act=%0h last=%0b required valid=1 act=%0h last=%0b",
                                 out_valid, Activation, out_last, prev_act, prev_last);
                    end
                end
                hs = out_valid && out_ready;
                nsat = 0;
                if (hs) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: act=%0h with empty scoreboard", Activation);
                    end else begin
                        e = sb.pop_front();
                        nsat = e.nsat;
                        for (int i = 0; i < CH; i++) begin
                            t = Activation[i*AW +: AW];
                            checks++;
                            if ($isunknown(t) || int'(t) != e.lane[i]) begin
                                errors++;
                                $display("FAIL lane%0d: got %0d expected %0d", i, int'(t), e.lane[i]);
                            end
                        end
                        chk("out_last", 64'(out_last), 64'(e.last));
                    end
                end
                if (clr_cnt) exp_cnt = 0;
                else if (hs) exp_cnt = (exp_cnt + nsat > CNT_MAX) ? CNT_MAX : exp_cnt + nsat;
                if (burst_on) begin
                    if (hs) seen_first = 1;
                    else if (seen_first && sb.size() > 0) gaps++;
                end
                prev_stall = out_valid && !out_ready;
                prev_act   = Activation;
                prev_last  = out_last;
                if (in_valid && in_ready) begin
                    pe.nsat = 0;
                    for (int i = 0; i < CH; i++) begin
                        pe.lane[i] = ref_lane(cur_lanes[i], int'(cfg_mode), int'(cfg_shift), sflag);
                        pe.nsat += int'(sflag);
                    end
                    pe.last = in_last;
                    sb.push_back(pe);
                    acc_cnt++;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc0, n, c0;
        logic [CH*AW-1:0] e1;
        rst = 1'b1; in_valid = 0; OFM = '0; in_last = 0; cfg_mode = 0; cfg_shift = 0; clr_cnt = 0;
        set4(0, 0, 0, 0);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_act", 64'(Activation), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // ReLU shift 4, latency of two cycles
        set4(1000, -1000, 0, 15);
        send(0, 4, 0);
        @(negedge clk);
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(out_valid), 64'd1);
        e1 = {9'd1, 9'd0, 9'd0, 9'd63};
        chk("relu_shift4", 64'(Activation), 64'(e1));
        @(posedge clk);
        #1;
        drain();
        chk("relu_cnt", 64'(sat_cnt), 64'd0);

        // Saturation counting
        set4(300, 0, 0, 0);   send(0, 0, 0); drain();
        chk("sat_one", 64'(sat_cnt), 64'd1);
        set4(300, 300, 300, 300); send(0, 0, 0); drain();
        chk("sat_four", 64'(sat_cnt), 64'd5);

        // Leaky and bypass
        set4(-80, -3000, -1, 200); send(1, 0, 0); drain();
        chk("leaky_cnt", 64'(sat_cnt), 64'd6);
        set4(-7, 6, 0, 0); send(2, 2, 0);
        // Shift at and beyond the word width: sign only
        for (int s = OFM_BIT; s < (1 << SHIFT_W); s++) begin
            set4(5, -5, (1 << (OFM_BIT - 1)) - 1, -(1 << (OFM_BIT - 1)));
            send(2, s, 0);
        end
        drain();

        // Backpressure: two beats absorbed, then toggled ready
        rdy_mode = 1;
        @(posedge clk);
        #1;
        acc0 = acc_cnt;
        bp_done = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    set4(100 * k + 16, -50 * k, 7 * k, 4000 - k);
                    send(k % 3, k, (k == 4));
                end
                bp_done = 1;
            end
        join_none
        repeat (6) @(negedge clk);
        chk("bp_accepts", 64'(acc_cnt - acc0), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rdy_mode = 2;
        n = 0;
        while (!bp_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("bp_sender_done", 64'(bp_done), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Full-rate burst with per-beat configuration
        rdy_mode = 0;
        @(posedge clk);
        #1;
        stall_total = 0;
        gaps = 0;
        seen_first = 0;
        burst_on = 1;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < CH; i++) cur_lanes[i] = rnd_lane();
            send(k % 4, (k * 7) % 32, k[0]);
        end
        drain();
        burst_on = 0;
        chk("burst_in_stalls", 64'(stall_total), 64'd0);
        chk("burst_out_gaps", 64'(gaps), 64'd0);

        // Reset with two beats in flight
        rdy_mode = 1;
        @(posedge clk);
        #1;
        set4(300, 300, 1, 2); send(0, 0, 0);
        set4(-300, 9, 1, 2);  send(2, 0, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cnt", 64'(sat_cnt), 64'd0);
        chk("mid_rst_act", 64'(Activation), 64'd0);
        sb.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_no_stale", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        set4(-7, 6, 40, -40); send(2, 2, 1);
        @(negedge clk);
        chk("post_rst_lat0", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("post_rst_lat1", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Randomized traffic with random backpressure and clears
        rdy_mode = 3;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < CH; i++) cur_lanes[i] = rnd_lane();
            clr_cnt = ($urandom_range(0, 15) == 0);
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
            clr_cnt = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        // Counter sticks at all-ones
        c0 = exp_cnt;
        set4(300, 300, 300, 300);
        for (int k = 0; k < 16400; k++) send(0, 0, 0);
        drain();
        @(negedge clk);
        chk("cnt_sticky", 64'(sat_cnt), 64'(CNT_MAX));
        chk("cnt_sticky_from", 64'(c0 <= CNT_MAX), 64'd1);
        @(posedge clk);
        #1;

        // Clear coinciding with a saturating output handshake
        send(0, 0, 0);
        @(posedge clk);
        #1;
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_wins", 64'(sat_cnt), 64'd0);
        @(posedge clk);
        #1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
